// File: rtl/rsa_pkg.sv
// rsa_pkg: sequencer state codes plus default operand width, index width, vector count and timeout
package rsa_pkg;
  localparam int DEF_RSA_WIDTH = 128;
  localparam int DEF_IDX_WIDTH = 32;
  localparam int DEF_NUM_VECTORS = 4;
  localparam int DEF_TIMEOUT_CYCLES = 4096;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_SELECT  = 3'd1;
  localparam state_t ST_LOAD    = 3'd2;
  localparam state_t ST_LAUNCH  = 3'd3;
  localparam state_t ST_WAIT    = 3'd4;
  localparam state_t ST_CAPTURE = 3'd5;
  localparam state_t ST_FINISH  = 3'd6;
endpackage

// File: rtl/rsa_vector_sequencer_if.sv
// rsa_vector_sequencer_if: run control, operand selector, modexp core and result/status signals (master = host side, slave = sequencer)
interface rsa_vector_sequencer_if import rsa_pkg::*; #(
  parameter int RSA_WIDTH = DEF_RSA_WIDTH,
  parameter int C_S_AXI_DATA_WIDTH = DEF_IDX_WIDTH
);
  logic START, ABORT, MODE_ALL;
  logic [C_S_AXI_DATA_WIDTH-1:0] SEL_IN, SELECT_OUT, RESULT_INDEX;
  logic [RSA_WIDTH-1:0] M_IN, E_IN, N_IN, CORE_M, CORE_E, CORE_N, CORE_RESULT, RESULT_OUT;
  logic CORE_START, CORE_DONE, RESULT_VALID, BUSY, DONE, TIMEOUT_ERR;
  modport master (
    output START, ABORT, MODE_ALL, SEL_IN, M_IN, E_IN, N_IN, CORE_DONE, CORE_RESULT,
    input SELECT_OUT, CORE_M, CORE_E, CORE_N, CORE_START, RESULT_OUT, RESULT_INDEX,
    input RESULT_VALID, BUSY, DONE, TIMEOUT_ERR
  );
  modport slave (
    input START, ABORT, MODE_ALL, SEL_IN, M_IN, E_IN, N_IN, CORE_DONE, CORE_RESULT,
    output SELECT_OUT, CORE_M, CORE_E, CORE_N, CORE_START, RESULT_OUT, RESULT_INDEX,
    output RESULT_VALID, BUSY, DONE, TIMEOUT_ERR
  );
endinterface

// File: rtl/rsa_timeout_counter.sv
// rsa_timeout_counter: clk/rst_n/clear/enable in, expired out; raises expired once LIMIT-1 enabled cycles have passed since clear
module rsa_timeout_counter #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == CW'(LIMIT - 1);
  always_comb cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rsa_vector_sequencer.sv
// rsa_vector_sequencer: S_AXI_ACLK/S_AXI_ARESETN plus slave bus; selects vectors, loads and launches the modexp core, captures results
module rsa_vector_sequencer import rsa_pkg::*; #(
  parameter int RSA_WIDTH = DEF_RSA_WIDTH,
  parameter int C_S_AXI_DATA_WIDTH = DEF_IDX_WIDTH,
  parameter int NUM_VECTORS = DEF_NUM_VECTORS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESETN,
  rsa_vector_sequencer_if.slave bus
);
  localparam logic [C_S_AXI_DATA_WIDTH-1:0] LAST = C_S_AXI_DATA_WIDTH'(NUM_VECTORS - 1);
  state_t state_q, state_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] idx_q, idx_d, ridx_q, ridx_d;
  logic [RSA_WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d, res_q, res_d;
  logic mode_q, mode_d, done_q, done_d, to_q, to_d, expired;
  rsa_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk(S_AXI_ACLK),
    .rst_n(S_AXI_ARESETN),
    .clear(state_q == ST_LAUNCH),
    .enable(state_q == ST_WAIT),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    ridx_d = ridx_q;
    mode_d = mode_q;
    done_d = done_q;
    to_d = to_q;
    m_d = m_q;
    e_d = e_q;
    n_d = n_q;
    res_d = res_q;
    if (bus.ABORT && state_q != ST_IDLE) state_d = ST_IDLE;
    else case (state_q)
      ST_IDLE: if (bus.START) begin
        state_d = ST_SELECT;
        idx_d = bus.MODE_ALL ? '0 : bus.SEL_IN;
        mode_d = bus.MODE_ALL;
        done_d = 1'b0;
        to_d = 1'b0;
      end
      ST_SELECT: state_d = ST_LOAD;
      ST_LOAD: begin
        m_d = bus.M_IN;
        e_d = bus.E_IN;
        n_d = bus.N_IN;
        state_d = ST_LAUNCH;
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: if (bus.CORE_DONE) begin
        res_d = bus.CORE_RESULT;
        ridx_d = idx_q;
        state_d = ST_CAPTURE;
      end else if (expired) begin
        to_d = 1'b1;
        state_d = ST_FINISH;
      end
      ST_CAPTURE: if (mode_q && idx_q < LAST) begin
        idx_d = idx_q + 1'b1;
        state_d = ST_SELECT;
      end else state_d = ST_FINISH;
      ST_FINISH: begin
        done_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      ridx_q <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      to_q <= 1'b0;
      m_q <= '0;
      e_q <= '0;
      n_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ridx_q <= ridx_d;
      mode_q <= mode_d;
      done_q <= done_d;
      to_q <= to_d;
      m_q <= m_d;
      e_q <= e_d;
      n_q <= n_d;
      res_q <= res_d;
    end
  assign bus.SELECT_OUT = idx_q;
  assign bus.CORE_M = m_q;
  assign bus.CORE_E = e_q;
  assign bus.CORE_N = n_q;
  assign bus.CORE_START = state_q == ST_LAUNCH;
  assign bus.RESULT_OUT = res_q;
  assign bus.RESULT_INDEX = ridx_q;
  assign bus.RESULT_VALID = state_q == ST_CAPTURE;
  assign bus.BUSY = state_q != ST_IDLE;
  assign bus.DONE = done_q;
  assign bus.TIMEOUT_ERR = to_q;
endmodule

// File: tb/tb_rsa_vector_sequencer.sv
// tb_rsa_vector_sequencer: randomized runs against a queue-based reference model with a decoupled result monitor
module tb_rsa_vector_sequencer;
  localparam int W = 128;
  localparam int IW = 32;
  localparam int NV = 4;
  localparam int TO = 16;
  typedef struct {
    logic [IW-1:0] idx;
    logic [W-1:0] res;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort_b = 1'b0;
  bit abort_with_done = 1'b0;
  int cyc = 0;
  int compared = 0;
  int failed = 0;
  int starts = 0;
  int first_start = -1;
  int done_cyc = -1;
  int to_cyc = -1;
  exp_t sb[$];
  int dq[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rsa_vector_sequencer_if #(.RSA_WIDTH(W), .C_S_AXI_DATA_WIDTH(IW)) bus ();
  rsa_vector_sequencer #(
    .RSA_WIDTH(W), .C_S_AXI_DATA_WIDTH(IW), .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TO)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .bus(bus)
  );
  function automatic logic [W-1:0] op(input logic [IW-1:0] i, input int k);
    logic [31:0] a;
    a = i ^ (32'(k) * 32'h3c6e_f372);
    return {a, i * 32'd3 + 32'(k), ~i, i + 32'h55 + 32'(k)};
  endfunction
  function automatic logic [W-1:0] fres(input logic [W-1:0] m, e, n);
    return (m ^ {e[63:0], e[127:64]}) + n;
  endfunction
  assign bus.M_IN = op(bus.SELECT_OUT, 0);
  assign bus.E_IN = op(bus.SELECT_OUT, 1);
  assign bus.N_IN = op(bus.SELECT_OUT, 2);
  assign bus.ABORT = abort_b;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (rst_n && bus.RESULT_VALID) begin
      if (sb.size() == 0) chk("unexpected_result_valid", {96'd0, bus.RESULT_INDEX}, '1);
      else begin
        x = sb.pop_front();
        chk("result_index", {96'd0, bus.RESULT_INDEX}, {96'd0, x.idx});
        chk("result_value", bus.RESULT_OUT, x.res);
      end
    end
  end
  initial begin
    int d;
    logic [W-1:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && bus.CORE_START) begin
        starts++;
        if (first_start < 0) first_start = cyc;
        d = dq.size() > 0 ? dq.pop_front() : -1;
        if (d >= 0) begin
          r = fres(bus.CORE_M, bus.CORE_E, bus.CORE_N);
          repeat (d) @(posedge clk);
          #1;
          bus.CORE_DONE = 1'b1;
          bus.CORE_RESULT = r;
          abort_b = abort_with_done;
          done_cyc = cyc;
          @(posedge clk);
          #1;
          bus.CORE_DONE = 1'b0;
          bus.CORE_RESULT = {4{$urandom}};
          abort_b = 1'b0;
        end
      end
    end
  end
  task automatic wait_idle(output int t_end, input int budget);
    t_end = -1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (bus.TIMEOUT_ERR && to_cyc < 0) to_cyc = cyc;
      if (!bus.BUSY) begin
        t_end = cyc;
        return;
      end
    end
    compared++;
    failed++;
    $display("FAIL run_bound: BUSY still 1 after %0d cycles, expected 0", budget);
  endtask
  task automatic do_run(input bit mode, input logic [IW-1:0] sel, input int kind, input int fix_d);
    int n, e, t_end;
    logic [IW-1:0] i;
    exp_t x;
    n = (kind == 0 && mode) ? NV : 1;
    for (int v = 0; v < n; v++) begin
      i = mode ? IW'(v) : sel;
      if (kind == 0) begin
        x.idx = i;
        x.res = fres(op(i, 0), op(i, 1), op(i, 2));
        sb.push_back(x);
      end
      dq.push_back(kind == 1 ? -1 : fix_d > 0 ? fix_d :
                   kind == 2 ? int'($urandom_range(3, 10)) : int'($urandom_range(1, TO)));
    end
    abort_with_done = (kind == 2);
    starts = 0;
    first_start = -1;
    to_cyc = -1;
    @(negedge clk);
    bus.START = 1'b1;
    bus.MODE_ALL = mode;
    bus.SEL_IN = sel;
    @(posedge clk);
    #1;
    e = cyc;
    bus.START = 1'b0;
    bus.SEL_IN = $urandom;
    chk("busy_after_start", {127'd0, bus.BUSY}, 1);
    chk("done_cleared", {127'd0, bus.DONE}, 0);
    chk("timeout_cleared", {127'd0, bus.TIMEOUT_ERR}, 0);
    @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    wait_idle(t_end, 600);
    chk("first_start_latency", W'(first_start - e), 2);
    chk("core_start_count", W'(starts), W'(n));
    if (kind == 0) begin
      chk("done_set", {127'd0, bus.DONE}, 1);
      chk("timeout_clear", {127'd0, bus.TIMEOUT_ERR}, 0);
      chk("results_outstanding", W'(sb.size()), 0);
    end else if (kind == 1) begin
      chk("timeout_latency", W'(to_cyc - e), W'(TO + 3));
      chk("timeout_done", {127'd0, bus.DONE}, 1);
      chk("timeout_err", {127'd0, bus.TIMEOUT_ERR}, 1);
    end else begin
      chk("abort_to_idle", W'(t_end), W'(done_cyc + 1));
      chk("abort_done", {127'd0, bus.DONE}, 0);
      chk("abort_timeout", {127'd0, bus.TIMEOUT_ERR}, 0);
    end
    abort_with_done = 1'b0;
    dq.delete();
    sb.delete();
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_flags"}, {122'd0, bus.BUSY, bus.DONE, bus.TIMEOUT_ERR, bus.RESULT_VALID,
        bus.CORE_START, 1'b0}, 0);
    chk({tag, "_select_out"}, {96'd0, bus.SELECT_OUT}, 0);
    chk({tag, "_result_index"}, {96'd0, bus.RESULT_INDEX}, 0);
    chk({tag, "_core_m"}, bus.CORE_M, 0);
    chk({tag, "_core_e"}, bus.CORE_E, 0);
    chk({tag, "_core_n"}, bus.CORE_N, 0);
    chk({tag, "_result_out"}, bus.RESULT_OUT, 0);
  endtask
  initial begin
    int r;
    bus.START = 1'b0;
    bus.MODE_ALL = 1'b0;
    bus.SEL_IN = '0;
    bus.CORE_DONE = 1'b0;
    bus.CORE_RESULT = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_run(1'b0, 32'd2, 0, 10);
    do_run(1'b1, 32'd0, 0, 0);
    do_run(1'b0, 32'd1, 0, TO);
    do_run(1'b0, 32'd3, 0, 1);
    for (int k = 0; k < 10; k++) begin
      r = int'($urandom_range(0, 7));
      do_run(1'(r & 1), r < 6 ? 32'(r % 4) : 32'hFFFF_FF00 | 32'(r), 0, 0);
    end
    do_run(1'b0, 32'd7, 1, 0);
    do_run(1'b1, 32'd0, 0, 0);
    do_run(1'b1, 32'd0, 2, 0);
    do_run(1'b0, 32'd1, 2, 0);
    dq.push_back(-1);
    starts = 0;
    @(negedge clk);
    bus.START = 1'b1;
    bus.MODE_ALL = 1'b0;
    bus.SEL_IN = 32'd5;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (6) @(negedge clk);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("busy_before_reset", {127'd0, bus.BUSY}, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midrun_reset");
    chk("repeat_start_ignored", W'(starts), 1);
    @(negedge clk);
    rst_n = 1'b1;
    dq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("no_second_run", {127'd0, bus.BUSY}, 0);
    do_run(1'b0, 32'd0, 0, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
